// File: rtl/bus_sync_rx.sv
// bus_sync_rx: destination-side bus synchronizer.
//
// Brings a multi-bit bus and its qualifying enable from a foreign clock domain
// into the clk domain. EN passes through a NUM_STAGES flop chain; a qualified
// enable event captures tx_data into a small show-ahead FIFO. ack returns the
// synchronized, one-cycle-delayed enable to the source for its handshake.
//
// Parameters:
//   BUS_WIDTH  - data width
//   NUM_STAGES - synchronizer flops on EN (>= 2)
//   DEPTH      - FIFO entries (power of 2, >= 2)
//   MODE       - 0: rising edge of EN marks a word, 1: any EN transition does
//
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   tx_data  - foreign-domain bus, held stable by the source handshake
//   EN       - foreign-domain enable, asynchronous to clk
//   rx_data  - FIFO head word (zero while empty)
//   rx_valid - FIFO not empty
//   rx_ready - consumer takes rx_data this cycle
//   ack      - delayed synchronized enable, back to the source
//   overflow - sticky: an event was dropped because the FIFO was full
//   count    - FIFO occupancy
module bus_sync_rx #(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MODE       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BUS_WIDTH-1:0]       tx_data,
    input  logic                       EN,
    output logic [BUS_WIDTH-1:0]       rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic                       ack,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [NUM_STAGES-1:0] sync_q;
    logic                  en_d_q;
    logic                  en_s;
    logic                  evt;

    logic [BUS_WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    logic                  full;
    logic                  pop;
    logic                  push;

    // Event detect on the synchronized enable.
    always_comb begin
        en_s = sync_q[NUM_STAGES-1];
        if (MODE == 0) begin
            evt = en_s & ~en_d_q;
        end else begin
            evt = en_s ^ en_d_q;
        end
    end

    // FIFO control. valid_q tracks count_q != 0, so a pop while empty is void
    // and an empty FIFO with a simultaneous push simply goes to one entry.
    always_comb begin
        full     = (count_q == CntFull);
        pop      = valid_q & rx_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push     = evt & (~full | pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        count_d  = count_q + CntW'(push) - CntW'(pop);
        valid_d  = (count_d != '0);
        // Dropped words still acknowledge via en_d; only this flag records the loss.
        ovf_d    = ovf_q | (evt & ~push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            en_d_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[NUM_STAGES-2:0], EN};
            en_d_q   <= en_s;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: rx_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        rx_data  = valid_q ? mem_q[rd_ptr_q] : '0;
        rx_valid = valid_q;
        ack      = en_d_q;
        overflow = ovf_q;
        count    = count_q;
    end

endmodule

// File: tb/tb_bus_sync_rx.sv
// tb_bus_sync_rx: three bus_sync_rx instances (level/2 stages, toggle/2 stages,
// level/3 stages) driven by directed handshakes and random traffic, checked
// every cycle against a queue-based model, plus literal expectations.
module tb_bus_sync_rx;

    localparam int DEPTH = 4;
    localparam int NS_T [3] = '{2, 2, 3};
    localparam int MODE_T [3] = '{0, 1, 0};

    logic       clk;
    logic       rst;
    logic [2:0] en;
    logic [2:0] rdy;
    logic [7:0] txd [3];
    logic [7:0] rxd [3];
    logic [2:0] vld;
    logic [2:0] ack;
    logic [2:0] ovf;
    logic [2:0] cnt [3];

    int n_checks = 0;
    int n_errs   = 0;
    bit armed    = 0;
    int lat [3];

    // Model state: EN samples since reset, FIFO contents, ack and overflow.
    bit         hist [3][$];
    logic [7:0] mq [3][$];
    bit         m_ack [3];
    bit         m_ovf [3];
    bit         m_s, m_d, m_evt, m_pop;

    logic [7:0] popped [3][$];
    logic [7:0] exp2 [3] = '{8'h99, 8'hFF, 8'h98};

    bus_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(2), .DEPTH(4), .MODE(0)) u_lvl2 (
        .clk(clk), .rst(rst), .tx_data(txd[0]), .EN(en[0]), .rx_data(rxd[0]),
        .rx_valid(vld[0]), .rx_ready(rdy[0]), .ack(ack[0]), .overflow(ovf[0]),
        .count(cnt[0])
    );
    bus_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(2), .DEPTH(4), .MODE(1)) u_tog2 (
        .clk(clk), .rst(rst), .tx_data(txd[1]), .EN(en[1]), .rx_data(rxd[1]),
        .rx_valid(vld[1]), .rx_ready(rdy[1]), .ack(ack[1]), .overflow(ovf[1]),
        .count(cnt[1])
    );
    bus_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(3), .DEPTH(4), .MODE(0)) u_lvl3 (
        .clk(clk), .rst(rst), .tx_data(txd[2]), .EN(en[2]), .rx_data(rxd[2]),
        .rx_valid(vld[2]), .rx_ready(rdy[2]), .ack(ack[2]), .overflow(ovf[2]),
        .count(cnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    // EN value sampled 'back' edges ago (0 before reset release).
    function automatic bit hbit(input int i, input int back);
        int sz;
        sz = hist[i].size();
        return (sz >= back) ? hist[i][sz-back] : 1'b0;
    endfunction

    // Model: a word is seen when EN, delayed NS edges, rises (level) or
    // changes (toggle); ack is that delayed EN one edge later.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                hist[i].delete();
                mq[i].delete();
                m_ack[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end else begin
                m_s   = hbit(i, NS_T[i]);
                m_d   = hbit(i, NS_T[i] + 1);
                m_evt = (MODE_T[i] == 1) ? (m_s ^ m_d) : (m_s & ~m_d);
                m_pop = (mq[i].size() != 0) && rdy[i];
                if (m_pop) void'(mq[i].pop_front());
                if (m_evt) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back(txd[i]);
                    else m_ovf[i] = 1'b1;
                end
                m_ack[i] = m_s;
                hist[i].push_back(en[i]);
                if (hist[i].size() > 8) void'(hist[i].pop_front());
            end
        end
    end

    // Words actually handed to the consumer by each DUT.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && rdy[i]) popped[i].push_back(rxd[i]);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk("rx_valid", i, 32'(vld[i]), 32'(mq[i].size() != 0));
                chk("rx_data", i, 32'(rxd[i]), (mq[i].size() != 0) ? 32'(mq[i][0]) : 32'd0);
                chk("count", i, 32'(cnt[i]), mq[i].size());
                chk("ack", i, 32'(ack[i]), 32'(m_ack[i]));
                chk("overflow", i, 32'(ovf[i]), 32'(m_ovf[i]));
            end
        end
    end

    // Drive EN of the masked instances to 'level' and wait for ack to match.
    task automatic hs(input logic [2:0] mask, input logic [2:0] level);
        int n;
        en = (en & ~mask) | (level & mask);
        n = 0;
        while ((((ack ^ level) & mask) != 3'b000) && n < 40) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 3; i++) begin
                if (mask[i] && vld[i] && lat[i] == 0) lat[i] = n;
            end
        end
        if (n >= 40) begin
            n_checks++;
            n_errs++;
            $display("FAIL handshake: ack %b never reached %b", ack & mask, level & mask);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // 1: reset with EN held high and AF on the bus.
        rst = 1'b1;
        en  = 3'b111;
        rdy = 3'b000;
        for (int i = 0; i < 3; i++) txd[i] = 8'hAF;
        @(negedge clk);
        armed = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_count", 0, 32'(cnt[0]), 1);
        chk("t1_data", 0, 32'(rxd[0]), 32'h0000_00AF);
        chk("t1_ack", 0, 32'(ack[0]), 1);
        chk("t1_count", 1, 32'(cnt[1]), 1);
        chk("t1_count", 2, 32'(cnt[2]), 0);
        @(negedge clk);
        chk("t1_count", 2, 32'(cnt[2]), 1);
        chk("t1_data", 2, 32'(rxd[2]), 32'h0000_00AF);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("t1_hold", i, 32'(cnt[i]), 1);
        rdy = 3'b111;
        en  = 3'b000;
        repeat (8) @(negedge clk);

        // 2 and 6: four-phase transfers on the 2-stage and 3-stage level instances.
        for (int i = 0; i < 3; i++) begin
            popped[i].delete();
            lat[i] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            txd[0] = exp2[k];
            txd[2] = exp2[k];
            hs(3'b101, 3'b101);
            hs(3'b101, 3'b000);
            if (k == 0) begin
                chk("t2_latency", 0, lat[0], 3);
                chk("t6_latency", 2, lat[2], 4);
            end
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i += 2) begin
            chk("t2_words", i, popped[i].size(), 3);
            for (int k = 0; k < 3; k++) begin
                chk("t2_word", i, (k < popped[i].size()) ? 32'(popped[i][k]) : 32'hDEAD,
                    32'(exp2[k]));
            end
            chk("t2_overflow", i, 32'(ovf[i]), 0);
        end

        // 3: toggle mode, six words into a 4-entry FIFO with no consumer.
        rdy[1] = 1'b0;
        popped[1].delete();
        for (int k = 1; k <= 6; k++) begin
            txd[1] = 8'(k);
            hs(3'b010, ~en);
        end
        chk("t3_count", 1, 32'(cnt[1]), 4);
        chk("t3_overflow", 1, 32'(ovf[1]), 1);
        chk("t3_head", 1, 32'(rxd[1]), 1);
        rdy[1] = 1'b1;
        repeat (4) @(negedge clk);
        rdy[1] = 1'b0;
        chk("t3_drained", 1, 32'(cnt[1]), 0);
        chk("t3_words", 1, popped[1].size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_word", 1, (k < popped[1].size()) ? 32'(popped[1][k]) : 32'hDEAD, k + 1);
        end

        // 4: full FIFO with an event and a pop on the same edge.
        rdy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            txd[0] = 8'hA1 + 8'(k);
            hs(3'b001, 3'b001);
            hs(3'b001, 3'b000);
        end
        chk("t4_full", 0, 32'(cnt[0]), 4);
        txd[0] = 8'h55;
        en[0]  = 1'b1;
        repeat (2) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        chk("t4_count", 0, 32'(cnt[0]), 4);
        chk("t4_overflow", 0, 32'(ovf[0]), 0);
        chk("t4_head", 0, 32'(rxd[0]), 32'h0000_00A2);
        hs(3'b001, 3'b000);

        // 5: reset while three words are stored and a transfer is in the chain.
        rdy[0] = 1'b1;
        repeat (6) @(negedge clk);
        rdy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            txd[0] = 8'hB1 + 8'(k);
            hs(3'b001, 3'b001);
            hs(3'b001, 3'b000);
        end
        chk("t5_count", 0, 32'(cnt[0]), 3);
        txd[0] = 8'h77;
        en[0]  = 1'b1;
        @(negedge clk);
        rst   = 1'b1;
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_count", i, 32'(cnt[i]), 0);
            chk("t5_valid", i, 32'(vld[i]), 0);
            chk("t5_ack", i, 32'(ack[i]), 0);
            chk("t5_overflow", i, 32'(ovf[i]), 0);
        end
        repeat (6) @(negedge clk);
        chk("t5_no_capture", 0, 32'(cnt[0]), 0);

        // Random traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            en  = 3'($urandom);
            rdy = 3'($urandom);
            for (int i = 0; i < 3; i++) txd[i] = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        rdy = 3'b111;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
